// File: rtl/obuft_bus_sequencer.sv
// obuft_bus_sequencer
//   Registered drive sequencer placed directly in front of a bank of
//   OBUFT_CTT-style tri-state pads. Words arrive over a valid/ready handshake.
//   Each drive burst is framed by TURN_CYC high-Z guard cycles before the first
//   driven word and after the last one. This keeps two masters sharing a CTT
//   bus from ever driving it at the same time. Losing GRANT releases the bus.
//
// Ports
//   C          in   clock, rising edge
//   CLR        in   asynchronous active-high reset
//   GRANT      in   bus ownership from the arbiter (1 = may drive)
//   REQ_VALID  in   REQ_DATA holds a word to drive
//   REQ_READY  out  word accepted when REQ_VALID & REQ_READY (combinational)
//   REQ_DATA   in   word to drive
//   PAD_I      out  per-bit pad data (registered)
//   PAD_T      out  per-bit pad enable, 1 = high-Z, all bits equal (registered)
//   BUSY       out  1 in every state except IDLE (registered)
//   ABORT      out  one-cycle pulse when grant is lost in LEAD or DRIVE (registered)
//
// The output flops are loaded from the next-state values. As a result, PAD_T,
// PAD_I and BUSY always line up with the state register and never lag it by
// a cycle.

module obuft_bus_sequencer #(
  parameter int WIDTH    = 8,
  parameter int TURN_CYC = 2,
  parameter int HOLD_CYC = 1
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             GRANT,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [WIDTH-1:0] REQ_DATA,
  output logic [WIDTH-1:0] PAD_I,
  output logic [WIDTH-1:0] PAD_T,
  output logic             BUSY,
  output logic             ABORT
);

  localparam int GW = (TURN_CYC + 1 > 2) ? $clog2(TURN_CYC + 1) : 1;
  localparam int HW = (HOLD_CYC + 1 > 2) ? $clog2(HOLD_CYC + 1) : 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(TURN_CYC - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEAD  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_TRAIL = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_n;
  logic [GW-1:0]    guard_r;
  logic [GW-1:0]    guard_n;
  logic [HW-1:0]    hold_r;
  logic [HW-1:0]    hold_n;
  logic [WIDTH-1:0] pad_i_r;
  logic [WIDTH-1:0] data_n;
  logic [WIDTH-1:0] pad_t_r;
  logic             busy_r;
  logic             abort_r;
  logic             abort_n;
  logic             ready_s;

  // Next-state, counter and handshake decode. pad_i_r doubles as the data latch.
  always_comb begin
    state_n = state_r;
    guard_n = guard_r;
    hold_n  = hold_r;
    data_n  = pad_i_r;
    abort_n = 1'b0;
    ready_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ready_s = GRANT;
        if (REQ_VALID && GRANT) begin
          data_n  = REQ_DATA;
          state_n = ST_LEAD;
          guard_n = GUARD_LOAD;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LEAD: begin
        // The bus has not been driven yet, so an abort drops straight back to IDLE.
        if (!GRANT) begin
          state_n = ST_IDLE;
          abort_n = 1'b1;
        end else if (guard_r == {GW{1'b0}}) begin
          state_n = ST_DRIVE;
          hold_n  = HOLD_LOAD;
        end else begin
          guard_n = guard_r - GW'(1);
        end
      end
      ST_DRIVE: begin
        ready_s = GRANT && (hold_r == {HW{1'b0}});
        if (!GRANT) begin
          state_n = ST_TRAIL;
          guard_n = GUARD_LOAD;
          abort_n = 1'b1;
        end else if (hold_r == {HW{1'b0}}) begin
          // A back-to-back accept reloads the word with no high-Z gap.
          if (REQ_VALID) begin
            data_n = REQ_DATA;
            hold_n = HOLD_LOAD;
          end else begin
            state_n = ST_TRAIL;
            guard_n = GUARD_LOAD;
          end
        end else begin
          hold_n = hold_r - HW'(1);
        end
      end
      ST_TRAIL: begin
        // GRANT is ignored here. The trailing guard always runs to completion.
        if (guard_r == {GW{1'b0}}) begin
          state_n = ST_IDLE;
        end else begin
          guard_n = guard_r - GW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        guard_n = {GW{1'b0}};
        hold_n  = {HW{1'b0}};
      end
    endcase
  end

  // State, counters and pad-facing output flops. CLR releases the pads at once.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_r <= ST_IDLE;
      guard_r <= {GW{1'b0}};
      hold_r  <= {HW{1'b0}};
      pad_i_r <= {WIDTH{1'b0}};
      pad_t_r <= {WIDTH{1'b1}};
      busy_r  <= 1'b0;
      abort_r <= 1'b0;
    end else begin
      state_r <= state_n;
      guard_r <= guard_n;
      hold_r  <= hold_n;
      pad_i_r <= data_n;
      pad_t_r <= (state_n == ST_DRIVE) ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
      busy_r  <= (state_n != ST_IDLE);
      abort_r <= abort_n;
    end
  end

  // REQ_READY is gated by CLR so that nothing can be accepted while reset is held.
  assign REQ_READY = ready_s & ~CLR;
  assign PAD_I     = pad_i_r;
  assign PAD_T     = pad_t_r;
  assign BUSY      = busy_r;
  assign ABORT     = abort_r;

endmodule

// File: tb/tb_obuft_bus_sequencer.sv
// Directed bench for obuft_bus_sequencer.
// Instance u_a uses the default parameters (TURN_CYC=2, HOLD_CYC=1).
// Instance u_b uses HOLD_CYC=2 for the back-to-back burst.
// Inputs change 1 time unit after a rising edge. Outputs are sampled there too.

module tb_obuft_bus_sequencer;

  logic       C = 1'b0;
  logic       CLR;
  logic       a_grant, a_valid, a_ready, a_busy, a_abort;
  logic [7:0] a_data, a_pad_i, a_pad_t;
  logic       b_grant, b_valid, b_ready, b_busy, b_abort;
  logic [7:0] b_data, b_pad_i, b_pad_t;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 C = ~C;

  obuft_bus_sequencer #(.WIDTH(8), .TURN_CYC(2), .HOLD_CYC(1)) u_a (
    .C(C), .CLR(CLR), .GRANT(a_grant), .REQ_VALID(a_valid), .REQ_READY(a_ready),
    .REQ_DATA(a_data), .PAD_I(a_pad_i), .PAD_T(a_pad_t), .BUSY(a_busy), .ABORT(a_abort)
  );

  obuft_bus_sequencer #(.WIDTH(8), .TURN_CYC(2), .HOLD_CYC(2)) u_b (
    .C(C), .CLR(CLR), .GRANT(b_grant), .REQ_VALID(b_valid), .REQ_READY(b_ready),
    .REQ_DATA(b_data), .PAD_I(b_pad_i), .PAD_T(b_pad_t), .BUSY(b_busy), .ABORT(b_abort)
  );

  task automatic tick;
    @(posedge C);
    #1;
  endtask

  task automatic test_reset;
    CLR = 1'b1;
    a_grant = 1'b0; a_valid = 1'b0; a_data = 8'h00;
    b_grant = 1'b0; b_valid = 1'b0; b_data = 8'h00;
    #2;
    n_cmp++; if (a_pad_t !== 8'hFF) begin n_bad++; $display("FAIL por_pad_t: got %h want ff", a_pad_t); end
    n_cmp++; if (a_pad_i !== 8'h00) begin n_bad++; $display("FAIL por_pad_i: got %h want 00", a_pad_i); end
    n_cmp++; if ({a_busy, a_abort, a_ready} !== 3'b000) begin n_bad++; $display("FAIL por_flags: got %b want 000", {a_busy, a_abort, a_ready}); end
    n_cmp++; if (b_pad_t !== 8'hFF) begin n_bad++; $display("FAIL por_b_pad_t: got %h want ff", b_pad_t); end
    tick(); tick();
    CLR = 1'b0;
    tick();
    // Bring u_a into DRIVE with A5, then assert CLR between clock edges.
    a_grant = 1'b1; a_valid = 1'b1; a_data = 8'hA5;
    tick();
    a_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (a_pad_t !== 8'h00) begin n_bad++; $display("FAIL rst_pre_drive: got %h want 00", a_pad_t); end
    #3;
    CLR = 1'b1;
    #1;
    n_cmp++; if (a_pad_t !== 8'hFF) begin n_bad++; $display("FAIL rst_mid_pad_t: got %h want ff", a_pad_t); end
    n_cmp++; if (a_pad_i !== 8'h00) begin n_bad++; $display("FAIL rst_mid_pad_i: got %h want 00", a_pad_i); end
    n_cmp++; if ({a_busy, a_abort, a_ready} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_flags: got %b want 000", {a_busy, a_abort, a_ready}); end
    tick();
    CLR = 1'b0;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", a_ready); end
    tick();
    // No trailing guard after reset: the sequencer stays idle and high-Z.
    n_cmp++; if ({a_busy, a_pad_t} !== {1'b0, 8'hFF}) begin n_bad++; $display("FAIL rst_after: got %b/%h want 0/ff", a_busy, a_pad_t); end
  endtask

  task automatic test_single_word;
    logic [7:0] exp_t [6];
    logic       exp_b [6];
    logic       exp_r [6];
    exp_t = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF};
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_r = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    a_grant = 1'b1; a_valid = 1'b1; a_data = 8'hA5;
    #1;
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL single_idle_ready: got %b want 1", a_ready); end
    for (int j = 0; j < 6; j++) begin
      tick();
      a_valid = 1'b0;
      n_cmp++; if (a_pad_t !== exp_t[j]) begin n_bad++; $display("FAIL single_pad_t[%0d]: got %h want %h", j, a_pad_t, exp_t[j]); end
      n_cmp++; if (a_pad_i !== 8'hA5) begin n_bad++; $display("FAIL single_pad_i[%0d]: got %h want a5", j, a_pad_i); end
      n_cmp++; if (a_busy !== exp_b[j]) begin n_bad++; $display("FAIL single_busy[%0d]: got %b want %b", j, a_busy, exp_b[j]); end
      n_cmp++; if (a_ready !== exp_r[j]) begin n_bad++; $display("FAIL single_ready[%0d]: got %b want %b", j, a_ready, exp_r[j]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_t [9];
    logic [7:0] exp_i [9];
    logic       exp_r [9];
    int         low_cnt;
    exp_t = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
    exp_i = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h5A, 8'h5A, 8'h3C, 8'h3C, 8'h3C};
    exp_r = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    low_cnt = 0;
    b_grant = 1'b1; b_valid = 1'b1; b_data = 8'hA5;
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_ready: got %b want 1", b_ready); end
    for (int j = 0; j < 9; j++) begin
      tick();
      if (j < 4) begin
        b_data = 8'h5A;
      end else if (j < 6) begin
        b_data = 8'h3C;
      end else begin
        b_valid = 1'b0;
      end
      #1;
      if (b_pad_t === 8'h00) low_cnt++;
      n_cmp++; if (b_pad_t !== exp_t[j]) begin n_bad++; $display("FAIL b2b_pad_t[%0d]: got %h want %h", j, b_pad_t, exp_t[j]); end
      n_cmp++; if (b_pad_i !== exp_i[j]) begin n_bad++; $display("FAIL b2b_pad_i[%0d]: got %h want %h", j, b_pad_i, exp_i[j]); end
      n_cmp++; if (b_ready !== exp_r[j]) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want %b", j, b_ready, exp_r[j]); end
    end
    n_cmp++; if (low_cnt != 6) begin n_bad++; $display("FAIL b2b_drive_len: got %0d want 6", low_cnt); end
    tick(); tick();
    n_cmp++; if (b_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_after: got %b want 0", b_busy); end
  endtask

  task automatic test_grant_loss_drive;
    logic [7:0] exp_t [8];
    logic       exp_b [8];
    int         aborts;
    exp_t = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    aborts = 0;
    a_grant = 1'b1; a_valid = 1'b1; a_data = 8'h11;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (j == 0) a_data = 8'h22;
      if (j == 2) a_grant = 1'b0;
      #1;
      if (a_abort === 1'b1) aborts++;
      n_cmp++; if (a_pad_t !== exp_t[j]) begin n_bad++; $display("FAIL gld_pad_t[%0d]: got %h want %h", j, a_pad_t, exp_t[j]); end
      n_cmp++; if (a_busy !== exp_b[j]) begin n_bad++; $display("FAIL gld_busy[%0d]: got %b want %b", j, a_busy, exp_b[j]); end
      n_cmp++; if (a_pad_i !== 8'h11) begin n_bad++; $display("FAIL gld_pad_i[%0d]: got %h want 11", j, a_pad_i); end
      if (j >= 2) begin
        n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL gld_ready[%0d]: got %b want 0", j, a_ready); end
      end
      if (j == 3) begin
        n_cmp++; if (a_abort !== 1'b1) begin n_bad++; $display("FAIL gld_abort_edge: got %b want 1", a_abort); end
      end
    end
    n_cmp++; if (aborts != 1) begin n_bad++; $display("FAIL gld_abort_count: got %0d want 1", aborts); end
    a_valid = 1'b0;
    a_grant = 1'b1;
  endtask

  task automatic test_grant_loss_lead;
    logic exp_a [4];
    logic exp_b [4];
    exp_a = '{1'b0, 1'b1, 1'b0, 1'b0};
    exp_b = '{1'b1, 1'b0, 1'b0, 1'b0};
    a_grant = 1'b1; a_valid = 1'b1; a_data = 8'h77;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (j == 0) begin
        a_grant = 1'b0;
        a_valid = 1'b0;
      end
      n_cmp++; if (a_pad_t !== 8'hFF) begin n_bad++; $display("FAIL gll_pad_t[%0d]: got %h want ff", j, a_pad_t); end
      n_cmp++; if (a_abort !== exp_a[j]) begin n_bad++; $display("FAIL gll_abort[%0d]: got %b want %b", j, a_abort, exp_a[j]); end
      n_cmp++; if (a_busy !== exp_b[j]) begin n_bad++; $display("FAIL gll_busy[%0d]: got %b want %b", j, a_busy, exp_b[j]); end
    end
    a_grant = 1'b1;
  endtask

  task automatic test_turnaround;
    logic exp_r [12];
    int   gap;
    int   gap_final;
    bit   seen;
    exp_r = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    gap = 0; gap_final = -1; seen = 1'b0;
    a_grant = 1'b1; a_valid = 1'b1; a_data = 8'hC3;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (j == 0) a_valid = 1'b0;
      if (j == 3) begin
        a_valid = 1'b1;
        a_data  = 8'h3C;
      end
      if (j == 6) a_valid = 1'b0;
      #1;
      if (a_pad_t === 8'h00) begin
        if (seen && gap > 0) gap_final = gap;
        seen = 1'b1;
        gap = 0;
      end else if (seen) begin
        gap++;
      end
      n_cmp++; if (a_ready !== exp_r[j]) begin n_bad++; $display("FAIL turn_ready[%0d]: got %b want %b", j, a_ready, exp_r[j]); end
      if (j == 2) begin
        n_cmp++; if (a_pad_i !== 8'hC3) begin n_bad++; $display("FAIL turn_word1: got %h want c3", a_pad_i); end
      end
      if (j == 8) begin
        n_cmp++; if ({a_pad_t, a_pad_i} !== {8'h00, 8'h3C}) begin n_bad++; $display("FAIL turn_word2: got %h/%h want 00/3c", a_pad_t, a_pad_i); end
      end
    end
    n_cmp++; if (gap_final < 4) begin n_bad++; $display("FAIL turn_gap: got %0d want >= 4", gap_final); end
    a_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_grant_loss_drive();
    test_grant_loss_lead();
    test_turnaround();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
